// File: rtl/stacker_pkg.sv
// Shared types and constants for the stacking game datapath.
package stacker_pkg;

  localparam int unsigned SCREEN_W  = 320;
  localparam int unsigned UNIT      = 4;
  localparam int unsigned INIT_SIZE = 4;
  localparam int unsigned MAX_ROWS  = 15;
  localparam int unsigned STEP_DIV  = 500000;

  // Playfield x coordinate and block size in units
  typedef logic [8:0] xcoord_t;
  typedef logic [3:0] bsize_t;

  typedef enum logic [2:0] {
    StIdle,
    StMove,
    StStop1,
    StStop2,
    StEval,
    StNext,
    StOver
  } state_t;

  // Block width in pixels; fits 9 bits for any 4-bit size with small units
  function automatic xcoord_t size_px(input bsize_t size, input int unsigned unit);
    return xcoord_t'(32'(size) * unit);
  endfunction

endpackage

// File: rtl/slider_step_timer.sv
// Step timer for the sliding block: counts 0..period-1 while enabled and pulses tick on the
// last count. Optional macro BLOCK_SLIDER_SPEEDUP_EN makes the period a register that shrinks
// by 1/8 on each speedup pulse, floored at STEP_DIV/4.
module slider_step_timer #(
  parameter int unsigned STEP_DIV = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic load,
  input  logic speedup,
  output logic tick
);

  localparam int unsigned CW        = $clog2(STEP_DIV + 1);
  localparam int unsigned FLOOR_INT = (STEP_DIV / 4 == 0) ? 1 : STEP_DIV / 4;
  localparam logic [CW-1:0] PeriodInit  = CW'(STEP_DIV);
  localparam logic [CW-1:0] PeriodFloor = CW'(FLOOR_INT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] period;
  logic          last;

`ifdef BLOCK_SLIDER_SPEEDUP_EN
  logic [CW-1:0] period_q;
  logic [CW-1:0] period_shrunk;
  logic [CW-1:0] period_next;

  // Next period after a speedup: remove one eighth, never below the floor
  always_comb begin
    period_shrunk = period_q - (period_q >> 3);
    period_next   = (period_shrunk < PeriodFloor) ? PeriodFloor : period_shrunk;
  end

  // Period register: reloaded while idle, shortened once per accepted row
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q <= PeriodInit;
    end else if (load) begin
      period_q <= PeriodInit;
    end else if (speedup) begin
      period_q <= period_next;
    end
  end

  assign period = period_q;
`else
  logic unused_period_ctrl;
  assign unused_period_ctrl = load ^ speedup;
  assign period             = PeriodInit;
`endif

  // Compare with >= so a shrinking period can never strand the counter above it
  assign last = (cnt_q >= (period - CW'(1)));
  assign tick = enable & last;

  // Step counter: cleared on request, otherwise wraps at the period while enabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      if (last) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/block_slider.sv
// Active-block driver for the stacking game: slides the block, freezes it on a stop press,
// runs a two-cycle stop_true handshake with the intersection checker and applies its verdict.
// Optional macro BLOCK_SLIDER_SPEEDUP_EN (handled in slider_step_timer) speeds up each row.
module block_slider #(
  parameter int unsigned SCREEN_W  = stacker_pkg::SCREEN_W,
  parameter int unsigned UNIT      = stacker_pkg::UNIT,
  parameter int unsigned INIT_SIZE = stacker_pkg::INIT_SIZE,
  parameter int unsigned STEP_DIV  = stacker_pkg::STEP_DIV,
  parameter int unsigned MAX_ROWS  = stacker_pkg::MAX_ROWS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_game,
  input  logic       stop_btn,
  input  logic       intersect_true,
  input  logic [8:0] inter_block_start,
  input  logic [8:0] inter_block_end,
  input  logic [3:0] inter_block_size,
  output logic       stop_true,
  output logic [8:0] curr_block_start,
  output logic [8:0] curr_block_end,
  output logic [3:0] curr_block_size,
  output logic [8:0] prev_block_start,
  output logic [8:0] prev_block_end,
  output logic [3:0] prev_block_size,
  output logic [3:0] row,
  output logic       game_over,
  output logic       game_won
);

  import stacker_pkg::*;

  localparam xcoord_t UnitX   = xcoord_t'(UNIT);
  localparam xcoord_t XMax    = xcoord_t'(SCREEN_W - 1);
  localparam bsize_t  InitSz  = bsize_t'(INIT_SIZE);
  localparam logic [4:0] RowsToWin = 5'(MAX_ROWS);

  state_t  state_q;
  logic    dir_right_q;
  xcoord_t curr_end_q;
  bsize_t  curr_size_q;
  xcoord_t prev_start_q;
  xcoord_t prev_end_q;
  bsize_t  prev_size_q;
  logic [3:0] row_q;
  logic    over_q;
  logic    won_q;

  xcoord_t curr_start;
  xcoord_t inter_diff;
  bsize_t  inter_units;
  logic    hit_right;
  logic    hit_left;
  logic    clear_game;
  logic    last_row;
  logic    step_tick;
  logic    unused_inter_size;

  // The checker's own size is not trusted; the overlap width is recomputed locally
  assign unused_inter_size = ^inter_block_size;

  // Combinational geometry and handshake decode
  always_comb begin
    curr_start  = curr_end_q + size_px(curr_size_q, UNIT);
    hit_right   = (curr_start + UnitX) > XMax;
    hit_left    = curr_end_q < UnitX;
    inter_diff  = inter_block_start - inter_block_end;
    inter_units = bsize_t'(inter_diff / UnitX);
    clear_game  = start_game && ((state_q == StIdle) || (state_q == StOver));
    last_row    = ({1'b0, row_q} + 5'd1) == RowsToWin;
  end

  slider_step_timer #(
    .STEP_DIV(STEP_DIV)
  ) u_step_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  ((state_q == StIdle) || (state_q == StNext)),
    .enable (state_q == StMove),
    .load   (state_q == StIdle),
    .speedup(state_q == StNext),
    .tick   (step_tick)
  );

  // Game FSM with all block, row and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      dir_right_q  <= 1'b1;
      curr_end_q   <= '0;
      curr_size_q  <= InitSz;
      prev_start_q <= '0;
      prev_end_q   <= '0;
      prev_size_q  <= '0;
      row_q        <= '0;
      over_q       <= 1'b0;
      won_q        <= 1'b0;
    end else if (clear_game) begin
      // IDLE starts a game; OVER returns to IDLE; both wipe the previous game
      state_q      <= (state_q == StIdle) ? StMove : StIdle;
      dir_right_q  <= 1'b1;
      curr_end_q   <= '0;
      curr_size_q  <= InitSz;
      prev_start_q <= '0;
      prev_end_q   <= '0;
      prev_size_q  <= '0;
      row_q        <= '0;
      over_q       <= 1'b0;
      won_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StMove: begin
          // A stop press beats a coincident step, freezing the current position
          if (stop_btn) begin
            state_q <= StStop1;
          end else if (step_tick) begin
            if (dir_right_q) begin
              if (hit_right) begin
                dir_right_q <= 1'b0;
              end else begin
                curr_end_q <= curr_end_q + UnitX;
              end
            end else begin
              if (hit_left) begin
                dir_right_q <= 1'b1;
              end else begin
                curr_end_q <= curr_end_q - UnitX;
              end
            end
          end
        end
        StStop1: state_q <= StStop2;
        StStop2: state_q <= StEval;
        StEval: begin
          if (row_q == 4'd0) begin
            prev_start_q <= curr_start;
            prev_end_q   <= curr_end_q;
            prev_size_q  <= curr_size_q;
            state_q      <= StNext;
          end else if (intersect_true && (inter_units != 4'd0)) begin
            prev_start_q <= inter_block_start;
            prev_end_q   <= inter_block_end;
            prev_size_q  <= inter_units;
            state_q      <= StNext;
          end else begin
            over_q  <= 1'b1;
            state_q <= StOver;
          end
        end
        StNext: begin
          row_q <= row_q + 4'd1;
          if (last_row) begin
            won_q   <= 1'b1;
            state_q <= StOver;
          end else begin
            curr_size_q <= prev_size_q;
            curr_end_q  <= '0;
            dir_right_q <= 1'b1;
            state_q     <= StMove;
          end
        end
        default: ; // StIdle and StOver wait for start_game
      endcase
    end
  end

  // stop_true is decoded from the state register so reset drops it immediately
  assign stop_true        = (state_q == StStop1) || (state_q == StStop2);
  assign curr_block_start = curr_start;
  assign curr_block_end   = curr_end_q;
  assign curr_block_size  = curr_size_q;
  assign prev_block_start = prev_start_q;
  assign prev_block_end   = prev_end_q;
  assign prev_block_size  = prev_size_q;
  assign row              = row_q;
  assign game_over        = over_q;
  assign game_won         = won_q;

endmodule

// File: tb/tb_block_slider.sv
// Scoreboard bench for block_slider: stimulus pushes expected stop/verdict results computed
// from a closed-form position model; a monitor pops them when the DUT raises stop_true.
module tb_block_slider;

  localparam int SW   = 320;
  localparam int U    = 4;
  localparam int INIT = 4;
  localparam int SD   = 4;
  localparam int MR   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_game = 1'b0;
  logic       stop_btn = 1'b0;
  logic       intersect_true = 1'b0;
  logic [8:0] inter_block_start = '0;
  logic [8:0] inter_block_end = '0;
  logic [3:0] inter_block_size = '0;
  logic       stop_true;
  logic [8:0] curr_block_start, curr_block_end, prev_block_start, prev_block_end;
  logic [3:0] curr_block_size, prev_block_size, row;
  logic       game_over, game_won;

  block_slider #(
    .SCREEN_W(SW), .UNIT(U), .INIT_SIZE(INIT), .STEP_DIV(SD), .MAX_ROWS(MR)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start_game       (start_game),
    .stop_btn         (stop_btn),
    .intersect_true   (intersect_true),
    .inter_block_start(inter_block_start),
    .inter_block_end  (inter_block_end),
    .inter_block_size (inter_block_size),
    .stop_true        (stop_true),
    .curr_block_start (curr_block_start),
    .curr_block_end   (curr_block_end),
    .curr_block_size  (curr_block_size),
    .prev_block_start (prev_block_start),
    .prev_block_end   (prev_block_end),
    .prev_block_size  (prev_block_size),
    .row              (row),
    .game_over        (game_over),
    .game_won         (game_won)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cend, cstart, csize;
    int row, pstart, pend, psize, over, won, csize_after, cend_after;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_row, m_pstart, m_pend, m_psize, m_csize, m_over, m_won;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Position after k steps: triangle wave between 0 and the last legal end, with one
  // idle tick at each wall for the bounce
  function automatic int pos_at(input int k, input int size);
    int n, p;
    n = (SW - 1 - size * U) / U;
    p = k % (2 * n + 2);
    return (p <= n) ? p * U : (2 * n + 1 - p) * U;
  endfunction

  task automatic model_start();
    m_row = 0; m_pstart = 0; m_pend = 0; m_psize = 0;
    m_csize = INIT; m_over = 0; m_won = 0;
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the first MOVE-sampling negedge
  task automatic start_pulse();
    start_game = 1'b1;
    @(negedge clk);
    start_game = 1'b0;
  endtask

  // mode 0: honest checker, 1: checker reports no overlap, 2: overlap narrower than a unit
  task automatic play_row(input int c, input int mode);
    exp_t e;
    int cend, cstart, left, right, it, is, ie, units, accept;
    repeat (c) @(negedge clk);
    cend   = pos_at(c / SD, m_csize);
    cstart = cend + m_csize * U;
    left   = (cend > m_pend) ? cend : m_pend;
    right  = (cstart < m_pstart) ? cstart : m_pstart;
    it = 0; is = 0; ie = 0;
    if (mode == 0 && right > left) begin
      it = 1; is = right; ie = left;
    end else if (mode == 2) begin
      it = 1; ie = cend; is = cend + 2;
    end
    units = (((is - ie) & 511) / U) & 15;
    intersect_true    = it[0];
    inter_block_start = 9'(is);
    inter_block_end   = 9'(ie);
    inter_block_size  = 4'(units);
    e.cend = cend; e.cstart = cstart; e.csize = m_csize;
    accept = (m_row == 0) || (it == 1 && units != 0);
    if (m_row == 0) begin
      m_pstart = cstart; m_pend = cend; m_psize = m_csize;
    end else if (accept) begin
      m_pstart = is; m_pend = ie; m_psize = units;
    end
    if (!accept) m_over = 1;
    else begin
      m_row++;
      if (m_row == MR) m_won = 1;
      else m_csize = m_psize;
    end
    e.row = m_row; e.pstart = m_pstart; e.pend = m_pend; e.psize = m_psize;
    e.over = m_over; e.won = m_won; e.csize_after = m_csize;
    e.cend_after = (m_over || m_won) ? cend : 0;
    sb.push_back(e);
    stop_btn = 1'b1;
    @(negedge clk);
    stop_btn = 1'b0;
    if (!m_over && !m_won) repeat (4) @(negedge clk);
    else repeat (6) @(negedge clk);
  endtask

  // Called in OVER: start_game must return to IDLE with a wiped game
  task automatic end_to_idle();
    start_pulse();
    chk("idle_row", int'(row), 0);
    chk("idle_over", int'(game_over), 0);
    chk("idle_won", int'(game_won), 0);
    chk("idle_curr_end", int'(curr_block_end), 0);
    chk("idle_curr_size", int'(curr_block_size), INIT);
    chk("idle_prev_start", int'(prev_block_start), 0);
    chk("idle_prev_size", int'(prev_block_size), 0);
    model_start();
  endtask

  // Monitor: pops an expectation on each stop_true rise, checks the handshake length and
  // the verdict two cycles after stop_true falls
  initial begin
    exp_t cur;
    int hi_cnt = 0, wait_cnt = -1;
    bit prev_st = 1'b0, have_cur = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        hi_cnt = 0; wait_cnt = -1; prev_st = 1'b0; have_cur = 1'b0;
        continue;
      end
      if (stop_true && !prev_st) begin
        hi_cnt = 1;
        if (sb.size() == 0) begin
          chk("unexpected_stop_true", 1, 0);
          have_cur = 1'b0;
        end else begin
          cur = sb.pop_front();
          have_cur = 1'b1;
          chk("frozen_end", int'(curr_block_end), cur.cend);
          chk("frozen_start", int'(curr_block_start), cur.cstart);
          chk("frozen_size", int'(curr_block_size), cur.csize);
        end
      end else if (stop_true) begin
        hi_cnt++;
        if (have_cur) chk("held_end", int'(curr_block_end), cur.cend);
      end
      if (!stop_true && prev_st) begin
        chk("stop_true_cycles", hi_cnt, 2);
        if (have_cur) wait_cnt = 2;
      end else if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          chk("row", int'(row), cur.row);
          chk("prev_start", int'(prev_block_start), cur.pstart);
          chk("prev_end", int'(prev_block_end), cur.pend);
          chk("prev_size", int'(prev_block_size), cur.psize);
          chk("game_over", int'(game_over), cur.over);
          chk("game_won", int'(game_won), cur.won);
          chk("next_size", int'(curr_block_size), cur.csize_after);
          chk("next_end", int'(curr_block_end), cur.cend_after);
          have_cur = 1'b0;
          wait_cnt = -1;
        end
      end
      prev_st = stop_true;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int guard;
    repeat (3) @(negedge clk);
    chk("rst_stop_true", int'(stop_true), 0);
    chk("rst_curr_end", int'(curr_block_end), 0);
    chk("rst_curr_size", int'(curr_block_size), INIT);
    chk("rst_curr_start", int'(curr_block_start), INIT * U);
    chk("rst_prev_start", int'(prev_block_start), 0);
    chk("rst_row", int'(row), 0);
    chk("rst_flags", int'({game_over, game_won}), 0);
    reset = 1'b0;
    @(negedge clk);

    // Game A: 100 -> 108 (trimmed to 2) -> 108, wins on the third row
    model_start();
    start_pulse();
    play_row(100, 0);
    play_row(108, 0);
    play_row(108, 0);
    chk("won_level", int'(game_won), 1);
    stop_btn = 1'b1;
    @(negedge clk);
    stop_btn = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("over_stop_ignored", int'(stop_true), 0);
    end
    chk("won_holds", int'(game_won), 1);
    end_to_idle();

    // Game B: stop coincident with a step at end 40, then a reported miss
    start_pulse();
    play_row(43, 0);
    play_row(int'($urandom_range(0, 400)), 1);
    chk("over_level", int'(game_over), 1);
    repeat (3) @(negedge clk);
    chk("over_holds", int'(game_over), 1);
    end_to_idle();

    // Game C: right wall at 300, bounce hold, then first step back to 296
    start_pulse();
    play_row(303, 0);
    play_row(307, 0);
    play_row(311, 0);
    end_to_idle();

    // Game D: overlap narrower than one unit counts as a miss
    start_pulse();
    play_row(int'($urandom_range(0, 300)), 0);
    play_row(int'($urandom_range(0, 300)), 2);
    end_to_idle();

    // Random games against the honest checker with occasional forced misses
    for (int g = 0; g < 6; g++) begin
      start_pulse();
      while (!m_over && !m_won)
        play_row(int'($urandom_range(0, 700)), ($urandom_range(0, 7) == 0) ? 1 : 0);
      end_to_idle();
    end

    // Reset during STOP2: stop_true must drop without waiting for a clock
    start_pulse();
    repeat (20) @(negedge clk);
    e.cend = pos_at(20 / SD, INIT); e.cstart = e.cend + INIT * U; e.csize = INIT;
    e.row = 0; e.pstart = 0; e.pend = 0; e.psize = 0; e.over = 0; e.won = 0;
    e.csize_after = INIT; e.cend_after = 0;
    sb.push_back(e);
    stop_btn = 1'b1;
    @(negedge clk);
    stop_btn = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_stop_true", int'(stop_true), 0);
    chk("async_curr_end", int'(curr_block_end), 0);
    chk("async_curr_size", int'(curr_block_size), INIT);
    chk("async_row", int'(row), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_start();
    // Back in IDLE: a stop press must not start a handshake
    stop_btn = 1'b1;
    @(negedge clk);
    stop_btn = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_after_reset_stop", int'(stop_true), 0);
    start_pulse();
    play_row(10, 0);

    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
